// File: rtl/uart_tx_sched_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module      : uart_pkg                                           |
// | Description : Shared types, widths and helpers for the UART TX   |
// |               message scheduler slice.                           |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package uart_pkg;

  // Width of one serialized byte and of one packed message word
  localparam int BYTE_W = 8;
  localparam int MSG_W  = 64;
  localparam int LEN_W  = 4;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Width of a binary index over n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Oversized lengths saturate at the number of bytes a word can hold
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int max_bytes);
    if (int'(len) > max_bytes) begin
      return LEN_W'(max_bytes);
    end
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module      : uart_tx_sched_if                                   |
// | Description : Request-side and byte-side handshake bundle of the |
// |               UART TX message scheduler.                         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 2
);
  import uart_pkg::*;

  // Message sources: offer, payload, byte count and one-hot accept
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*MSG_W-1:0] req_data;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       req_ready;

  // Byte stream towards the serializer
  logic [BYTE_W-1:0]        tx_byte;
  logic                     tx_valid;
  logic                     tx_ready;

  // Environment side: the requesters plus the serializer
  modport master (
    output req_valid, req_data, req_len, tx_ready,
    input  req_ready, tx_byte, tx_valid
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_data, req_len, tx_ready,
    output req_ready, tx_byte, tx_valid
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module      : rr_arbiter                                         |
// | Description : Combinational round-robin picker. Returns the first|
// |               active request at or above the pointer, wrapping.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
)(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  logic w_found;

  // Two passes: pointer..top first, then bottom..pointer-1 for the wrap
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (i_en && !w_found && i_req[j] && (j >= int'(i_ptr))) begin
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
        w_found    = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (i_en && !w_found && i_req[j] && (j < int'(i_ptr))) begin
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
        w_found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module      : uart_tx_sched                                      |
// | Description : Round-robin scheduler sharing one UART byte        |
// |               transmitter between several message sources, with  |
// |               an enforced idle gap after every message.          |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 16,
  parameter int MAX_BYTES  = 8
)(
  input  logic                          CLK100MHZ,
  input  logic                          rst_n,
  uart_tx_sched_if.slave                bus,
  output logic                          busy,
  output logic [idx_width(NUM_REQ)-1:0] grant_id,
  output logic                          msg_done
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_SEND = ST_SEND;
  localparam logic [1:0] S_GAP  = ST_GAP;

  // Registered state
  logic [1:0]         r_state;
  logic [MSG_W-1:0]   r_shift;
  logic [LEN_W-1:0]   r_cnt;
  logic [GAP_W-1:0]   r_gap;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic               r_done;

  // Arbitration and capture path
  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_next_ptr;
  logic [MSG_W-1:0]   w_sel_data;
  logic [LEN_W-1:0]   w_sel_len;
  logic [LEN_W-1:0]   w_len_c;
  logic               w_accept;
  logic               w_last_byte;

  // Offers are only considered while idle; GAP and SEND hold everyone off
  assign w_arb_en = (r_state == S_IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Grant is combinational; reset forces it low even though state is IDLE
  assign bus.req_ready = w_grant & {NUM_REQ{rst_n}};
  assign w_accept      = |w_grant;

  // Mux the winner's payload using the one-hot grant so losers stay don't-care
  always_comb begin
    w_sel_data = '0;
    w_sel_len  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_sel_data = bus.req_data[j*MSG_W +: MSG_W];
        w_sel_len  = bus.req_len[j*LEN_W +: LEN_W];
      end
    end
  end

  assign w_len_c     = clamp_len(w_sel_len, MAX_BYTES);
  assign w_next_ptr  = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
  assign w_last_byte = (r_cnt == LEN_W'(1));

  // Byte interface is decoded from state so reset drops tx_valid at once
  assign bus.tx_valid = (r_state == S_SEND);
  assign bus.tx_byte  = (r_state == S_SEND) ? r_shift[BYTE_W-1:0] : '0;

  assign busy     = (r_state != S_IDLE);
  assign grant_id = r_grant;
  assign msg_done = r_done;

  // Scheduler FSM: capture in IDLE, shift out LSB-first in SEND, wait out GAP
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= w_sel_data;
            r_cnt   <= w_len_c;
            r_grant <= w_idx;
            r_ptr   <= w_next_ptr;
            if (w_len_c != '0) begin
              r_state <= S_SEND;
            end else begin
              // Empty message: report completion, no gap is owed
              r_done <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            r_shift <= r_shift >> BYTE_W;
            r_cnt   <= r_cnt - 1'b1;
            if (w_last_byte) begin
              r_done <= 1'b1;
              if (GAP_CYCLES > 0) begin
                r_state <= S_GAP;
                r_gap   <= GAP_LOAD;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module      : tb_uart_tx_sched                                   |
// | Description : Self-checking bench for uart_tx_sched with a       |
// |               queue-based message model and directed scenarios.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_uart_tx_sched;

  localparam int NREQ = 2;
  localparam int GAP  = 16;

  logic       CLK100MHZ = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [0:0] grant_id;
  logic       msg_done;

  uart_tx_sched_if #(.NUM_REQ(NREQ)) bus();

  uart_tx_sched #(
    .NUM_REQ    (NREQ),
    .GAP_CYCLES (GAP),
    .MAX_BYTES  (8)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .grant_id  (grant_id),
    .msg_done  (msg_done)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected DUT event (t=%0t)", name, $time);
  endtask

  // Model: a message is a queue of bytes still owed, then a count of idle cycles owed
  logic [7:0]     m_q[$];
  int             m_gap, m_ptr, m_grant;
  bit             m_done;

  // Observations from the DUT, cleared per scenario
  logic [NREQ-1:0] acc_flag;
  logic [7:0]      got_bytes[$];
  int              got_grants[$];
  int              acc_cyc[$];
  int              done_cnt, busy_cnt, valid_cnt, first_valid, cyc;

  // Per-cycle compare against the model, then advance the model across the next edge
  always @(negedge CLK100MHZ) begin
    int              win, cand, n, l;
    bit              ev;
    logic [NREQ-1:0] er;
    logic [63:0]     d;
    if (!rst_n) begin
      m_q.delete();
      m_gap   = 0;
      m_ptr   = 0;
      m_grant = 0;
      m_done  = 1'b0;
    end
    ev  = (m_q.size() > 0);
    win = -1;
    if (rst_n && !ev && m_gap == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (m_ptr + k) % NREQ;
        for (int j = 0; j < NREQ; j++)
          if (win < 0 && j == cand && bus.req_valid[j]) win = j;
      end
    end
    er = '0;
    for (int j = 0; j < NREQ; j++) if (j == win) er[j] = 1'b1;

    chk("tx_valid",  64'(bus.tx_valid),  64'(ev));
    chk("tx_byte",   64'(bus.tx_byte),   ev ? 64'(m_q[0]) : 64'd0);
    chk("busy",      64'(busy),          64'(ev || (m_gap > 0)));
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("grant_id",  64'(grant_id),      64'(m_grant));
    chk("msg_done",  64'(msg_done),      64'(m_done));

    if (bus.tx_valid && bus.tx_ready) got_bytes.push_back(bus.tx_byte);
    for (int j = 0; j < NREQ; j++) begin
      if (bus.req_valid[j] && bus.req_ready[j]) begin
        got_grants.push_back(j);
        acc_cyc.push_back(cyc);
      end
    end
    acc_flag = acc_flag | (bus.req_valid & bus.req_ready);
    if (msg_done) done_cnt++;
    if (busy) busy_cnt++;
    if (bus.tx_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
    end
    cyc++;

    if (rst_n) begin
      m_done = 1'b0;
      if (win >= 0) begin
        d = '0;
        l = 0;
        for (int j = 0; j < NREQ; j++) begin
          if (j == win) begin
            d = bus.req_data[64*j +: 64];
            l = int'(bus.req_len[4*j +: 4]);
          end
        end
        n = (l > 8) ? 8 : l;
        for (int b = 0; b < 8; b++) if (b < n) m_q.push_back(d[8*b +: 8]);
        m_grant = win;
        m_ptr   = (win + 1) % NREQ;
        if (n == 0) m_done = 1'b1;
      end else if (ev) begin
        if (bus.tx_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_done = 1'b1;
            m_gap  = GAP;
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end
    end
  end

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic clear_rec();
    got_bytes.delete();
    got_grants.delete();
    acc_cyc.delete();
    done_cnt    = 0;
    busy_cnt    = 0;
    valid_cnt   = 0;
    first_valid = -1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_req(input int i, input logic [63:0] d, input logic [3:0] l);
    for (int j = 0; j < NREQ; j++) begin
      if (j == i) begin
        bus.req_data[64*j +: 64] = d;
        bus.req_len[4*j +: 4]    = l;
      end
    end
  endtask

  // Offer one message and withdraw it on the cycle after it is accepted
  task automatic send_one(input int i, input logic [63:0] d, input logic [3:0] l);
    logic [NREQ-1:0] mask;
    mask = NREQ'(1) << i;
    set_req(i, d, l);
    acc_flag      = acc_flag & ~mask;
    bus.req_valid = bus.req_valid | mask;
    for (int t = 0; t < 100 && (acc_flag & mask) == '0; t++) tick();
    if ((acc_flag & mask) == '0) timeout("accept");
    bus.req_valid = bus.req_valid & ~mask;
  endtask

  // Both requesters offer at once; each withdraws after its own accept
  task automatic run_two(input logic [63:0] d0, input logic [3:0] l0,
                         input logic [63:0] d1, input logic [3:0] l1);
    set_req(0, d0, l0);
    set_req(1, d1, l1);
    acc_flag      = '0;
    bus.req_valid = 2'b11;
    for (int t = 0; t < 200 && acc_flag != 2'b11; t++) begin
      tick();
      bus.req_valid = bus.req_valid & ~acc_flag;
    end
    if (acc_flag != 2'b11) timeout("accept_two");
    bus.req_valid = '0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 300 && busy; t++) tick();
    if (busy) timeout("idle");
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] e2[8];
    int         g2[4];
    logic [5:0] pat;

    e2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    g2 = '{0, 1, 0, 1};
    acc_flag      = '0;
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data  = '0;
    bus.req_len   = '0;
    bus.tx_ready  = 1'b1;
    clear_rec();
    cyc = 0;

    // Reset state, with both requests pending to show req_ready is held low
    #12;
    chk("rst_tx_valid",  64'(bus.tx_valid),  64'd0);
    chk("rst_tx_byte",   64'(bus.tx_byte),   64'd0);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_grant_id",  64'(grant_id),      64'd0);
    chk("rst_msg_done",  64'(msg_done),      64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single 8-byte message
    clear_rec();
    send_one(0, 64'h8877665544332211, 4'd8);
    wait_idle();
    chk("t1_nbytes", 64'(got_bytes.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_bytes.size()) chk("t1_byte", 64'(got_bytes[i]), 64'((i + 1) * 17));
    chk("t1_grants",  64'(got_grants.size()), 64'd1);
    chk("t1_latency", 64'(first_valid - acc_cyc[0]), 64'd1);
    chk("t1_done",    64'(done_cnt), 64'd1);
    chk("t1_busy",    64'(busy_cnt), 64'd24);

    // Contention from a reset pointer, two rounds
    apply_reset();
    clear_rec();
    run_two(64'h000000000000BBAA, 4'd2, 64'h000000000000DDCC, 4'd2);
    wait_idle();
    run_two(64'h000000000000BBAA, 4'd2, 64'h000000000000DDCC, 4'd2);
    wait_idle();
    chk("t2_ngrants", 64'(got_grants.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_grants.size()) chk("t2_grant", 64'(got_grants[i]), 64'(g2[i]));
    chk("t2_nbytes", 64'(got_bytes.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_bytes.size()) chk("t2_byte", 64'(got_bytes[i]), 64'(e2[i]));
    chk("t2_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd19);
    chk("t2_done",    64'(done_cnt), 64'd4);

    // Backpressure: ready pattern 1,0,0,1,0,1 from the first SEND cycle
    clear_rec();
    pat = 6'b101001;
    send_one(0, 64'hA5A5A5A5A5332211, 4'd3);
    for (int k = 0; k < 6; k++) begin
      bus.tx_ready = pat[k];
      tick();
    end
    bus.tx_ready = 1'b1;
    wait_idle();
    chk("t3_nbytes", 64'(got_bytes.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < got_bytes.size()) chk("t3_byte", 64'(got_bytes[i]), 64'((i + 1) * 17));
    chk("t3_valid_cycles", 64'(valid_cnt), 64'd6);

    // Zero-length message: accepted, completes, never sends or waits
    clear_rec();
    send_one(0, 64'h0000000000000001, 4'd0);
    wait_idle();
    chk("t4_len0_grants", 64'(got_grants.size()), 64'd1);
    chk("t4_len0_valid",  64'(valid_cnt), 64'd0);
    chk("t4_len0_done",   64'(done_cnt),  64'd1);
    chk("t4_len0_busy",   64'(busy_cnt),  64'd0);

    // Oversized length saturates at eight bytes
    clear_rec();
    send_one(1, 64'hF0E0D0C0B0A09080, 4'd12);
    wait_idle();
    chk("t4_len12_nbytes", 64'(got_bytes.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_bytes.size()) chk("t4_len12_byte", 64'(got_bytes[i]), 64'(8'h80 + 16 * i));

    // Reset in the middle of a message
    clear_rec();
    send_one(0, 64'h8877665544332211, 4'd8);
    for (int t = 0; t < 20 && got_bytes.size() < 3; t++) tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx_valid",  64'(bus.tx_valid),  64'd0);
    chk("t5_rst_busy",      64'(busy),          64'd0);
    chk("t5_rst_tx_byte",   64'(bus.tx_byte),   64'd0);
    chk("t5_rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("t5_partial",       64'(got_bytes.size()), 64'd3);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_rec();
    send_one(1, 64'h0F0E0D0C0B0A0908, 4'd8);
    wait_idle();
    chk("t5_nbytes", 64'(got_bytes.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_bytes.size()) chk("t5_byte", 64'(got_bytes[i]), 64'(8 + i));
    chk("t5_grant_id", 64'(grant_id), 64'd1);

    // Request raised during GAP and withdrawn before IDLE
    apply_reset();
    clear_rec();
    send_one(0, 64'h000000000000005A, 4'd1);
    for (int t = 0; t < 20 && !(busy && !bus.tx_valid); t++) tick();
    bus.req_valid = 2'b10;
    tick();
    tick();
    tick();
    chk("t6_in_gap", 64'(busy && !bus.tx_valid), 64'd1);
    bus.req_valid = '0;
    wait_idle();
    chk("t6_grants",   64'(got_grants.size()), 64'd1);
    chk("t6_grant_id", 64'(grant_id), 64'd0);
    clear_rec();
    run_two(64'h0000000000000001, 4'd1, 64'h0000000000000002, 4'd1);
    wait_idle();
    chk("t6_ngrants", 64'(got_grants.size()), 64'd2);
    if (got_grants.size() == 2) begin
      chk("t6_first",  64'(got_grants[0]), 64'd1);
      chk("t6_second", 64'(got_grants[1]), 64'd0);
    end
    chk("t6_nbytes", 64'(got_bytes.size()), 64'd2);
    if (got_bytes.size() == 2) begin
      chk("t6_byte0", 64'(got_bytes[0]), 64'h02);
      chk("t6_byte1", 64'(got_bytes[1]), 64'h01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
